// File: rtl/merged_pin_splitter.sv
// Splits a time-multiplexed merged pin back into NUM_PINS parallel values.
// Frames start with a sync marker on slot 0. pins_out updates only when a frame completes.
module merged_pin_splitter #(
  parameter int unsigned          NUM_PINS  = 4,
  parameter int unsigned          TIMEOUT   = 16,
  parameter logic [NUM_PINS-1:0]  RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                frame_sync,
  input  logic                merged_in,
  output logic [NUM_PINS-1:0] pins_out,
  output logic                out_valid,
  output logic                frame_err,
  output logic                locked
);

  localparam int unsigned SlotW      = $clog2(NUM_PINS);
  localparam logic [SlotW-1:0] LastSlot   = SlotW'(NUM_PINS - 1);
  localparam logic [7:0]       TimeoutVal = 8'(TIMEOUT);

  typedef enum logic [1:0] {StHunt, StCapture, StExpectSync} state_e;

  state_e              state_q, state_d;
  logic [SlotW-1:0]    slot_q, slot_d;
  logic [NUM_PINS-1:0] shadow_q, shadow_d;
  logic [NUM_PINS-1:0] pins_q, pins_d;
  logic [7:0]          idle_q, idle_d;
  logic                out_valid_q, out_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                locked_q, locked_d;

  logic [NUM_PINS-1:0] shadow_wr;
  logic [NUM_PINS-1:0] shadow_first;

  always_comb begin
    shadow_wr         = shadow_q;
    shadow_wr[slot_q] = merged_in;
    shadow_first      = {{(NUM_PINS-1){1'b0}}, merged_in};

    state_d     = state_q;
    slot_d      = slot_q;
    shadow_d    = shadow_q;
    pins_d      = pins_q;
    idle_d      = idle_q;
    locked_d    = locked_q;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      StHunt: begin
        if (in_valid && frame_sync) begin
          shadow_d = shadow_first;
          slot_d   = SlotW'(1);
          idle_d   = '0;
          state_d  = StCapture;
        end
      end
      StCapture: begin
        if (in_valid) begin
          idle_d = '0;
          if (frame_sync) begin
            // Early sync: drop the partial frame and resync on this beat.
            frame_err_d = 1'b1;
            locked_d    = 1'b0;
            shadow_d    = shadow_first;
            slot_d      = SlotW'(1);
          end else if (slot_q == LastSlot) begin
            pins_d      = shadow_wr;
            out_valid_d = 1'b1;
            locked_d    = 1'b1;
            slot_d      = '0;
            state_d     = StExpectSync;
          end else begin
            shadow_d = shadow_wr;
            slot_d   = slot_q + SlotW'(1);
          end
        end else if (TIMEOUT != 0) begin
          if (idle_q + 8'd1 == TimeoutVal) begin
            frame_err_d = 1'b1;
            locked_d    = 1'b0;
            slot_d      = '0;
            idle_d      = '0;
            state_d     = StHunt;
          end else begin
            idle_d = idle_q + 8'd1;
          end
        end
      end
      StExpectSync: begin
        if (in_valid) begin
          if (frame_sync) begin
            shadow_d = shadow_first;
            slot_d   = SlotW'(1);
            idle_d   = '0;
            state_d  = StCapture;
          end else begin
            frame_err_d = 1'b1;
            locked_d    = 1'b0;
            state_d     = StHunt;
          end
        end
      end
      default: state_d = StHunt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StHunt;
      slot_q      <= '0;
      shadow_q    <= '0;
      pins_q      <= RESET_VAL;
      idle_q      <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      shadow_q    <= shadow_d;
      pins_q      <= pins_d;
      idle_q      <= idle_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      locked_q    <= locked_d;
    end
  end

  assign pins_out  = pins_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_merged_pin_splitter.sv
// Directed and randomized bench for merged_pin_splitter against a queue-based frame model.
module tb_merged_pin_splitter;

  localparam int unsigned NP = 4;
  localparam int unsigned TO = 3;
  localparam logic [NP-1:0] RV = 4'b1010;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          frame_sync = 1'b0;
  logic          merged_in = 1'b0;
  logic [NP-1:0] pins_out;
  logic          out_valid;
  logic          frame_err;
  logic          locked;

  merged_pin_splitter #(
    .NUM_PINS (NP),
    .TIMEOUT  (TO),
    .RESET_VAL(RV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .frame_sync(frame_sync),
    .merged_in (merged_in),
    .pins_out  (pins_out),
    .out_valid (out_valid),
    .frame_err (frame_err),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: 0 = hunting, 1 = collecting bits, 2 = waiting for next sync.
  int        m_mode = 0;
  bit        m_bits[$];
  int        m_idle = 0;
  logic [NP-1:0] m_pins = RV;
  bit        m_ov = 0;
  bit        m_err = 0;
  bit        m_lock = 0;

  task automatic model_step(input bit r, input bit v, input bit s, input bit d);
    m_ov  = 0;
    m_err = 0;
    if (r) begin
      m_mode = 0;
      m_bits.delete();
      m_idle = 0;
      m_pins = RV;
      m_lock = 0;
    end else if (!v) begin
      if (m_mode == 1) begin
        m_idle++;
        if (m_idle == TO) begin
          m_err  = 1;
          m_lock = 0;
          m_bits.delete();
          m_mode = 0;
          m_idle = 0;
        end
      end
    end else begin
      m_idle = 0;
      case (m_mode)
        0: if (s) begin
          m_bits.delete();
          m_bits.push_back(d);
          m_mode = 1;
        end
        1: begin
          if (s) begin
            m_err  = 1;
            m_lock = 0;
            m_bits.delete();
            m_bits.push_back(d);
          end else begin
            m_bits.push_back(d);
            if (m_bits.size() == NP) begin
              for (int i = 0; i < NP; i++) m_pins[i] = m_bits[i];
              m_ov   = 1;
              m_lock = 1;
              m_bits.delete();
              m_mode = 2;
            end
          end
        end
        default: begin
          if (s) begin
            m_bits.delete();
            m_bits.push_back(d);
            m_mode = 1;
          end else begin
            m_err  = 1;
            m_lock = 0;
            m_mode = 0;
          end
        end
      endcase
    end
  endtask

  task automatic step(input bit r, input bit v, input bit s, input bit d);
    rst        = r;
    in_valid   = v;
    frame_sync = s;
    merged_in  = d;
    @(posedge clk);
    model_step(r, v, s, d);
    #1;
    check_eq("pins_out", 32'(pins_out), 32'(m_pins));
    check_eq("out_valid", 32'(out_valid), 32'(m_ov));
    check_eq("frame_err", 32'(frame_err), 32'(m_err));
    check_eq("locked", 32'(locked), 32'(m_lock));
  endtask

  // Sends one frame; bits[i] is slot i.
  task automatic send_frame(input logic [NP-1:0] bits);
    for (int i = 0; i < NP; i++) step(0, 1, (i == 0), bits[i]);
  endtask

  int phase = 0;
  int err_seen = 0;

  initial begin
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    check_eq("reset_pins", 32'(pins_out), 32'(RV));
    check_eq("reset_locked", 32'(locked), 32'd0);

    // Single frame: slots 1,0,1,1.
    send_frame(4'b1101);
    check_eq("frame1_pins", 32'(pins_out), 32'hd);
    check_eq("frame1_ov", 32'(out_valid), 32'd1);
    check_eq("frame1_lock", 32'(locked), 32'd1);

    // Back-to-back frames with no bubble.
    send_frame(4'b1101);
    send_frame(4'b0110);
    check_eq("b2b_pins", 32'(pins_out), 32'h6);

    // Early sync at slot 2, then resync frame 0,1,1,0.
    step(0, 1, 1, 1);
    step(0, 1, 0, 1);
    step(0, 1, 1, 0);
    check_eq("early_err", 32'(frame_err), 32'd1);
    check_eq("early_lock", 32'(locked), 32'd0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    check_eq("early_pins", 32'(pins_out), 32'h6);
    check_eq("early_relock", 32'(locked), 32'd1);

    // Missing sync, then non-sync beats stay silent in hunt.
    step(0, 1, 0, 1);
    check_eq("nosync_err", 32'(frame_err), 32'd1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, i[0]);

    // Timeout after two beats.
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_eq("timeout_err", 32'(frame_err), 32'd1);
    check_eq("timeout_pins", 32'(pins_out), 32'h6);
    send_frame(4'b1001);
    check_eq("after_to_pins", 32'(pins_out), 32'h9);

    // Reset mid-frame.
    step(0, 1, 1, 1);
    step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    check_eq("midrst_pins", 32'(pins_out), 32'(RV));
    check_eq("midrst_err", 32'(frame_err), 32'd0);
    send_frame(4'b0011);
    check_eq("postrst_pins", 32'(pins_out), 32'h3);

    // Randomized traffic, mostly well-framed with occasional faults.
    for (int n = 0; n < 1500; n++) begin
      bit r, v, s, d;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 4) != 0);
      d = 1'($urandom);
      if (phase == 0) s = ($urandom_range(0, 9) != 0);
      else            s = ($urandom_range(0, 11) == 0);
      if (v) phase = (phase + 1) % NP;
      if (r) phase = 0;
      step(r, v, s, d);
      if (out_valid && frame_err) err_seen++;
    end
    check_eq("ov_err_exclusive", 32'(err_seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/merged_pin_splitter.md
# merged_pin_splitter

Receive-side counterpart to pin merging. Accepts a time-multiplexed stream on a single merged pin and splits it back into `NUM_PINS` parallel pin values, framed by a sync marker on slot 0. Sits at the boundary of a hierarchical tile, between the merged physical pin and the logical module pins it feeds. Parallel outputs update atomically once per complete frame.

## Interface
- `NUM_PINS`, 4: logical pins carried per frame; legal range 2..32.
- `TIMEOUT`, 16: max idle cycles (no `in_valid`) allowed inside a frame before abort; 0 disables; legal range 0..255.
- `RESET_VAL`, 0: value of `pins_out` after reset (`NUM_PINS` bits).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  qualifies `merged_in` / `frame_sync` this cycle.
- `frame_sync`  in  1  marks the slot-0 beat of a frame; sampled only with `in_valid`.
- `merged_in`  in  1  serial data bit for the current slot.
- `pins_out`  out  `NUM_PINS`  last complete frame; bit i = slot i.
- `out_valid`  out  1  one-cycle pulse when `pins_out` updates.
- `frame_err`  out  1  one-cycle pulse on any framing error.
- `locked`  out  1  high after a good frame, low after error or reset.

## Operation
- States: HUNT, CAPTURE, EXPECT_SYNC. Slot counter `slot` of width clog2(NUM_PINS). Shadow register holds partial frame; `pins_out` is never partially updated.
- HUNT: `in_valid & frame_sync` → shadow[0]=`merged_in`, slot=1, go CAPTURE. `in_valid & !frame_sync` → ignored, no error.
- CAPTURE, beat with `in_valid & !frame_sync`: shadow[slot]=`merged_in`. If slot==NUM_PINS-1, frame complete: `pins_out` ← shadow with this bit, `out_valid`=1, `locked`=1, slot=0, go EXPECT_SYNC. Otherwise slot+1.
- CAPTURE, beat with `in_valid & frame_sync` (early sync): `frame_err`=1, `locked`=0, partial frame discarded, shadow[0]=`merged_in`, slot=1, stay CAPTURE (resync on this beat).
- EXPECT_SYNC: `in_valid & frame_sync` → shadow[0]=`merged_in`, slot=1, go CAPTURE. `in_valid & !frame_sync` → `frame_err`=1, `locked`=0, go HUNT; the beat is dropped.
- Idle timeout (CAPTURE only, TIMEOUT>0): idle counter increments on every cycle with `in_valid`=0, clears on any accepted beat. Reaching TIMEOUT → `frame_err`=1, `locked`=0, partial frame discarded, go HUNT. No timeout in HUNT or EXPECT_SYNC.
- Inactive `in_valid`: no state change other than the idle count; `frame_sync`/`merged_in` are don't-care.
- `pins_out` holds its value through errors and timeouts. It changes only on frame completion or reset.

## Timing
- Reset values: `pins_out`=RESET_VAL, `out_valid`=0, `frame_err`=0, `locked`=0. State is HUNT, slot=0, idle count=0.
- `rst` has priority over all inputs in the same cycle. Reset mid-frame discards the partial frame with no `frame_err`.
- Latency: `pins_out`, `out_valid` and `locked` are registered. They become visible the cycle after the final slot beat is sampled.
- Back-to-back frames at full rate: one frame per NUM_PINS cycles, with no bubble required. A sync on the beat right after completion is accepted.
- `frame_err` is registered and asserts the cycle after the offending beat or timeout-expiry cycle. `out_valid` and `frame_err` are never high together.
- Timeout fires on the TIMEOUT-th consecutive idle cycle in CAPTURE. `frame_err` is visible one cycle later.

## Test plan
- NUM_PINS=4, reset, then beats (sync=1,d=1),(0,0),(0,1),(0,1) on consecutive cycles → next cycle `pins_out`=4'b1101, `out_valid` pulses once, `locked`=1.
- Two back-to-back frames 1,0,1,1 then 0,1,1,0 with no gaps → `out_valid` pulses 4 cycles apart; `pins_out`=4'b1101 then 4'b0110; `frame_err` never asserts.
- Early sync: beats (1,1),(0,1), then sync at slot 2 with d=0, followed by (0,1),(0,1),(0,0) → `frame_err` pulses once; then `pins_out`=4'b0110; `locked` goes low, then high again.
- Missing sync after a good frame: beat (sync=0) in EXPECT_SYNC → `frame_err` pulse, `locked`=0, state HUNT. Further non-sync beats produce no error and no `out_valid`.
- TIMEOUT=3: two beats of a frame, then `in_valid` low for 3 cycles → `frame_err` pulse; `pins_out` unchanged. A new full frame is then accepted normally.
- `rst` asserted after 2 beats of a frame → `pins_out`=RESET_VAL, no `frame_err`, `locked`=0. A full frame after reset is decoded correctly.
